write_master: RTL and testbench
===============================

// Module: write_master
// PURPOSE
//  DMA write-side stage, directly downstream of the read master's FIFO. Pops 32-bit words
//  from a show-ahead FIFO and writes them to an Avalon-MM slave at consecutive word
//  addresses from iWM_startaddress, iLength bytes total. Signals completion on oDone.
// PARAMETERS
//  ADDR_W   32  width of start address and write address
//  LEN_W    32  width of byte-length input and remaining-byte counter
// PORTS
//  iClk              in   1       system clock, all logic on rising edge
//  iReset            in   1       asynchronous, active-high reset
//  iStart            in   1       1-cycle start pulse; latches address and length
//  iLength           in   LEN_W   transfer length in bytes
//  iWM_startaddress  in   ADDR_W  byte address of first write (word aligned, [1:0]=0)
//  iWM_waitrequest   in   1       Avalon-MM slave stall
//  oWM_write         out  1       Avalon-MM write strobe
//  oWM_writeaddress  out  ADDR_W  Avalon-MM byte address
//  oWM_writedata     out  32      Avalon-MM write data
//  oWM_byteenable    out  4       byte lanes (only with WM_BYTEENABLE_EN)
//  iFF_empty         in   1       FIFO empty
//  iFF_q             in   32      FIFO head word, valid while iFF_empty=0 (show-ahead)
//  oFF_readrequest   out  1       FIFO pop, combinational, 1 cycle per word
//  oBusy             out  1       transfer in progress (state != IDLE/DONE)
//  oDone             out  1       level; set when transfer ends, cleared by next accepted iStart
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; oWM_write=0, oWM_writeaddress=0, oWM_writedata=0,
//   oWM_byteenable=4'hF, oBusy=0, oDone=0, rem=0; oFF_readrequest=0. Takes effect mid-burst.
//  States IDLE, WAIT_DATA, WRITE, DONE (2-bit encoding from dma_pkg).
//  IDLE/DONE + iStart: addr<=iWM_startaddress, rem<=iLength, oDone<=0, -> WAIT_DATA.
//  iStart while oBusy=1 is ignored (no restart, no abort of an in-flight write).
//  WAIT_DATA: rem==0 -> DONE (oDone<=1 next edge; zero-length completes in 2 cycles).
//   else if iFF_empty=0: oFF_readrequest=1 this cycle, oWM_writedata<=iFF_q,
//   oWM_write<=1, -> WRITE. iFF_empty=1: hold, no pop.
//  WRITE: hold oWM_write/address/data/byteenable stable while iWM_waitrequest=1.
//   iWM_waitrequest=0: oWM_write<=0, addr<=addr+4, rem<=rem-min(rem,4), -> WAIT_DATA.
//  Peak rate: 1 word per 2 cycles. Exactly one pop per write; never pop when iFF_empty=1.
//  Arithmetic: addr wraps modulo 2^ADDR_W; rem never underflows (saturating subtract).
//  FIFO going empty mid-transfer only stalls WAIT_DATA; no data lost or duplicated.
// CONFIGURATION
//  WM_BYTEENABLE_EN defined: oWM_byteenable exists; all words 4'hF except final word when
//   rem<4: rem=1->4'h1, 2->4'h3, 3->4'h7. Word count = ceil(iLength/4).
//  Not defined: port absent; iLength[1:0] ignored (treated as 0); word count = iLength>>2;
//   rem decrements by exactly 4.
// STRUCTURE
//  dma_pkg: state encodings WM_IDLE/WM_WAIT_DATA/WM_WRITE/WM_DONE, WORD_BYTES=4,
//   BE_FULL=4'hF. One sub-module: wm_byteenable_gen (rem[LEN_W-1:0] -> 4-bit enable),
//   instantiated only under WM_BYTEENABLE_EN.
// TESTING
//  1 start=0x1000, len=16, FIFO holds A,B,C,D, waitrequest=0 -> writes 0x1000..0x100C data
//    A..D, 4 pops, oDone=1 after last write, oBusy=0.
//  2 len=8, waitrequest high 3 cycles on first write -> addr/data/write stable 4 cycles, 1 pop.
//  3 len=12, FIFO empty 5 cycles after 1st word -> no pop/write while empty, then resumes
//    at 0x..04; total 3 pops.
//  4 len=0 -> no write, no pop, oDone=1 two cycles after iStart; iStart during busy ignored.
//  5 iReset asserted while oWM_write=1 -> write, pop, oBusy, oDone drop same cycle.
//  6 WM_BYTEENABLE_EN, len=6 -> 2 writes, byteenable 4'hF then 4'h3; without macro 1 write.

Source files
------------

// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the DMA write-side stage:
//   wm_state_e  - 2-bit write master FSM encoding
//   WORD_BYTES  - bytes moved per Avalon-MM word
//   BE_FULL     - byteenable value with all four lanes active
// -----------------------------------------------------------------------------
package dma_pkg;

  typedef enum logic [1:0] {
    WM_IDLE      = 2'd0,
    WM_WAIT_DATA = 2'd1,
    WM_WRITE     = 2'd2,
    WM_DONE      = 2'd3
  } wm_state_e;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] BE_FULL    = 4'hF;

endpackage

// File: rtl/wm_byteenable_gen.sv
// -----------------------------------------------------------------------------
// wm_byteenable_gen
// Maps the remaining byte count of a transfer to the byte lanes of the word
// currently being written. A full word (or an idle count of zero) enables all
// lanes; a final partial word of 1..3 bytes enables only the low lanes.
// Used by write_master only when WM_BYTEENABLE_EN is defined.
// Ports:
//   i_rem         in   LEN_W  remaining byte count
//   o_byteenable  out  4      byte lane enables
// -----------------------------------------------------------------------------
module wm_byteenable_gen
  import dma_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic [LEN_W-1:0] i_rem,
  output logic [3:0]       o_byteenable
);

  localparam logic [LEN_W-1:0] LP_WORD = LEN_W'(WORD_BYTES);

  always_comb begin
    o_byteenable = BE_FULL;
    if (i_rem < LP_WORD) begin
      case (i_rem[1:0])
        2'd1:    o_byteenable = 4'h1;
        2'd2:    o_byteenable = 4'h3;
        2'd3:    o_byteenable = 4'h7;
        default: o_byteenable = BE_FULL;
      endcase
    end
  end

endmodule

// File: rtl/write_master.sv
// -----------------------------------------------------------------------------
// write_master
// DMA write-side stage. Pops 32-bit words from a show-ahead FIFO and writes
// them to an Avalon-MM slave at consecutive word addresses starting at
// iWM_startaddress, iLength bytes in total, then raises oDone.
//
// Optional feature macro: WM_BYTEENABLE_EN
//   defined     - oWM_byteenable port exists; final partial word gets a
//                 partial lane mask; word count = ceil(iLength/4)
//   not defined - no byteenable port; iLength[1:0] ignored; word count =
//                 iLength>>2
//
// Ports:
//   iClk, iReset            clock, asynchronous active-high reset
//   iStart                  1-cycle start pulse, accepted only when idle/done
//   iLength                 transfer length in bytes
//   iWM_startaddress        word-aligned byte address of first write
//   iWM_waitrequest         Avalon-MM slave stall
//   oWM_write               Avalon-MM write strobe
//   oWM_writeaddress        Avalon-MM byte address
//   oWM_writedata           Avalon-MM write data
//   oWM_byteenable          byte lanes (WM_BYTEENABLE_EN only)
//   iFF_empty, iFF_q        show-ahead FIFO status and head word
//   oFF_readrequest         FIFO pop, combinational, one cycle per word
//   oBusy                   transfer in progress
//   oDone                   level, set at end of transfer, cleared by next start
//   oDbg_state              current FSM state (dma_pkg::wm_state_e encoding)
//
// Handshakes: a FIFO word is consumed in the cycle oFF_readrequest=1, which is
// only ever asserted while iFF_empty=0. An Avalon write is accepted on the
// rising edge where oWM_write=1 and iWM_waitrequest=0; until then address,
// data, byteenable and write are held unchanged.
// -----------------------------------------------------------------------------
module write_master
  import dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 32
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iStart,
  input  logic [LEN_W-1:0]  iLength,
  input  logic [ADDR_W-1:0] iWM_startaddress,
  input  logic              iWM_waitrequest,
  output logic              oWM_write,
  output logic [ADDR_W-1:0] oWM_writeaddress,
  output logic [31:0]       oWM_writedata,
`ifdef WM_BYTEENABLE_EN
  output logic [3:0]        oWM_byteenable,
`endif
  input  logic              iFF_empty,
  input  logic [31:0]       iFF_q,
  output logic              oFF_readrequest,
  output logic              oBusy,
  output logic              oDone,
  output logic [1:0]        oDbg_state
);

  localparam logic [LEN_W-1:0]  LP_LEN_WORD  = LEN_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] LP_ADDR_WORD = ADDR_W'(WORD_BYTES);

  wm_state_e         r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr,  w_addr_next;
  logic [LEN_W-1:0]  r_rem,   w_rem_next;
  logic              r_write, w_write_next;
  logic [31:0]       r_data,  w_data_next;
  logic              r_done,  w_done_next;
  logic              w_pop;
  logic [LEN_W-1:0]  w_len_eff;
  logic [LEN_W-1:0]  w_rem_dec;

`ifdef WM_BYTEENABLE_EN
  assign w_len_eff = iLength;
`else
  // Without lane masking a trailing partial word cannot be expressed, so the
  // length is truncated to whole words.
  assign w_len_eff = iLength & ~LEN_W'(3);
`endif

  // Saturating subtract of one word; a short final word drains rem to zero.
  assign w_rem_dec = (r_rem > LP_LEN_WORD) ? (r_rem - LP_LEN_WORD) : '0;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_state <= WM_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_write <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_rem   <= w_rem_next;
      r_write <= w_write_next;
      r_data  <= w_data_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_rem_next   = r_rem;
    w_write_next = r_write;
    w_data_next  = r_data;
    w_done_next  = r_done;
    w_pop        = 1'b0;
    case (r_state)
      WM_IDLE, WM_DONE: begin
        if (iStart) begin
          w_addr_next  = iWM_startaddress;
          w_rem_next   = w_len_eff;
          w_done_next  = 1'b0;
          w_state_next = WM_WAIT_DATA;
        end
      end
      WM_WAIT_DATA: begin
        if (r_rem == '0) begin
          w_done_next  = 1'b1;
          w_state_next = WM_DONE;
        end else if (!iFF_empty) begin
          w_pop        = 1'b1;
          w_data_next  = iFF_q;
          w_write_next = 1'b1;
          w_state_next = WM_WRITE;
        end
      end
      WM_WRITE: begin
        if (!iWM_waitrequest) begin
          w_write_next = 1'b0;
          w_addr_next  = r_addr + LP_ADDR_WORD;
          w_rem_next   = w_rem_dec;
          w_state_next = WM_WAIT_DATA;
        end
      end
      default: w_state_next = WM_IDLE;
    endcase
  end

`ifdef WM_BYTEENABLE_EN
  // rem only changes on write acceptance, so the mask is stable during a stall.
  wm_byteenable_gen #(
    .LEN_W (LEN_W)
  ) u_byteenable_gen (
    .i_rem        (r_rem),
    .o_byteenable (oWM_byteenable)
  );
`endif

  assign oWM_write        = r_write;
  assign oWM_writeaddress = r_addr;
  assign oWM_writedata    = r_data;
  assign oFF_readrequest  = w_pop;
  assign oBusy            = (r_state == WM_WAIT_DATA) || (r_state == WM_WRITE);
  assign oDone            = r_done;
  assign oDbg_state       = r_state;

endmodule

// File: tb/tb_write_master.sv
// -----------------------------------------------------------------------------
// tb_write_master
// Directed bench for write_master: a queue models the show-ahead FIFO, and a
// scoreboard holds the expected Avalon writes (address, data, byteenable).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge or 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_write_master;

  localparam int ADDR_W = 32;
  localparam int LEN_W  = 32;

  // ---------------- clock / reset ----------------
  logic iClk = 1'b0;
  logic iReset;
  always #5 iClk = ~iClk;

  logic              iStart;
  logic [LEN_W-1:0]  iLength;
  logic [ADDR_W-1:0] iWM_startaddress;
  logic              iWM_waitrequest;
  logic              oWM_write;
  logic [ADDR_W-1:0] oWM_writeaddress;
  logic [31:0]       oWM_writedata;
`ifdef WM_BYTEENABLE_EN
  logic [3:0]        oWM_byteenable;
`endif
  logic              iFF_empty;
  logic [31:0]       iFF_q;
  logic              oFF_readrequest;
  logic              oBusy;
  logic              oDone;
  logic [1:0]        oDbg_state;

  write_master #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) dut (
    .iClk             (iClk),
    .iReset           (iReset),
    .iStart           (iStart),
    .iLength          (iLength),
    .iWM_startaddress (iWM_startaddress),
    .iWM_waitrequest  (iWM_waitrequest),
    .oWM_write        (oWM_write),
    .oWM_writeaddress (oWM_writeaddress),
    .oWM_writedata    (oWM_writedata),
`ifdef WM_BYTEENABLE_EN
    .oWM_byteenable   (oWM_byteenable),
`endif
    .iFF_empty        (iFF_empty),
    .iFF_q            (iFF_q),
    .oFF_readrequest  (oFF_readrequest),
    .oBusy            (oBusy),
    .oDone            (oDone),
    .oDbg_state       (oDbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;
  int n_writes = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [3:0]  exp_be_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic update_fifo();
    iFF_empty = (fifo_q.size() == 0);
    iFF_q     = (fifo_q.size() != 0) ? fifo_q[0] : 32'hDEAD_BEEF;
  endtask

  task automatic clear_fifo();
    fifo_q.delete();
    update_fifo();
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] be);
    exp_addr_q.push_back(addr);
    exp_q.push_back(data);
    exp_be_q.push_back(be);
  endtask

  // One clock: sample pop/write on the falling edge, then advance the FIFO
  // model just after the rising edge.
  task automatic cycle();
    logic        pop_now;
    logic [31:0] tmp;
    logic [3:0]  be_exp;
    @(negedge iClk);
    pop_now = oFF_readrequest;
    if (pop_now) begin
      n_pops++;
      check_eq("pop_while_empty", {31'd0, iFF_empty}, 32'd0);
    end
    if (oWM_write && !iWM_waitrequest) begin
      n_writes++;
      check_eq("write_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
      if (exp_q.size() != 0) begin
        check_eq("wr_addr", oWM_writeaddress, exp_addr_q.pop_front());
        check_eq("wr_data", oWM_writedata, exp_q.pop_front());
        be_exp = exp_be_q.pop_front();
`ifdef WM_BYTEENABLE_EN
        check_eq("wr_be", {28'd0, oWM_byteenable}, {28'd0, be_exp});
`endif
      end
    end
    @(posedge iClk);
    #1;
    if (pop_now && fifo_q.size() != 0) tmp = fifo_q.pop_front();
    update_fifo();
  endtask

  task automatic start(input logic [31:0] addr, input logic [31:0] len);
    iWM_startaddress = addr;
    iLength          = len;
    iStart           = 1'b1;
    cycle();
    iStart           = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int k = 0;
    while (!oDone && k < budget) begin
      cycle();
      k++;
    end
    check_eq({tag, "_done"}, {31'd0, oDone}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int p0;
    int w0;
    iReset           = 1'b1;
    iStart           = 1'b0;
    iLength          = '0;
    iWM_startaddress = '0;
    iWM_waitrequest  = 1'b0;
    clear_fifo();

    // Reset state
    repeat (3) @(posedge iClk);
    #1;
    check_eq("rst_write", {31'd0, oWM_write}, 32'd0);
    check_eq("rst_addr", oWM_writeaddress, 32'd0);
    check_eq("rst_data", oWM_writedata, 32'd0);
    check_eq("rst_busy", {31'd0, oBusy}, 32'd0);
    check_eq("rst_done", {31'd0, oDone}, 32'd0);
    check_eq("rst_pop", {31'd0, oFF_readrequest}, 32'd0);
    check_eq("rst_state", {30'd0, oDbg_state}, 32'd0);
`ifdef WM_BYTEENABLE_EN
    check_eq("rst_be", {28'd0, oWM_byteenable}, 32'hF);
`endif
    iReset = 1'b0;

    // 1: 16 bytes, no stalls
    fifo_q = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C, 32'hD000_000D};
    update_fifo();
    n_pops = 0; n_writes = 0;
    expect_write(32'h1000, 32'hA000_000A, 4'hF);
    expect_write(32'h1004, 32'hB000_000B, 4'hF);
    expect_write(32'h1008, 32'hC000_000C, 4'hF);
    expect_write(32'h100C, 32'hD000_000D, 4'hF);
    start(32'h1000, 32'd16);
    check_eq("t1_busy_start", {31'd0, oBusy}, 32'd1);
    check_eq("t1_done_start", {31'd0, oDone}, 32'd0);
    run_until_done(40, "t1");
    check_eq("t1_pops", n_pops, 32'd4);
    check_eq("t1_writes", n_writes, 32'd4);
    check_eq("t1_exp_left", exp_q.size(), 32'd0);
    check_eq("t1_busy_end", {31'd0, oBusy}, 32'd0);

    // 2: 8 bytes, 3 waitrequest cycles on the first word, restart attempt ignored
    fifo_q = '{32'hE000_000E, 32'hF000_000F};
    update_fifo();
    n_pops = 0; n_writes = 0;
    iWM_waitrequest = 1'b1;
    expect_write(32'h2000, 32'hE000_000E, 4'hF);
    expect_write(32'h2004, 32'hF000_000F, 4'hF);
    start(32'h2000, 32'd8);
    cycle();
    for (int i = 0; i < 4; i++) begin
      check_eq("t2_stall_write", {31'd0, oWM_write}, 32'd1);
      check_eq("t2_stall_addr", oWM_writeaddress, 32'h2000);
      check_eq("t2_stall_data", oWM_writedata, 32'hE000_000E);
      check_eq("t2_stall_pops", n_pops, 32'd1);
      if (i == 3) break;
      if (i == 1) begin
        iWM_startaddress = 32'h9000;
        iLength          = 32'd64;
        iStart           = 1'b1;
      end
      cycle();
      iStart = 1'b0;
    end
    iWM_waitrequest = 1'b0;
    run_until_done(40, "t2");
    check_eq("t2_pops", n_pops, 32'd2);
    check_eq("t2_writes", n_writes, 32'd2);
    check_eq("t2_exp_left", exp_q.size(), 32'd0);
    check_eq("t2_final_addr", oWM_writeaddress, 32'h2008);

    // 3: 12 bytes, FIFO empty for 5 cycles after the first word
    fifo_q = '{32'h6666_0001};
    update_fifo();
    n_pops = 0; n_writes = 0;
    expect_write(32'h3000, 32'h6666_0001, 4'hF);
    expect_write(32'h3004, 32'h6666_0002, 4'hF);
    expect_write(32'h3008, 32'h6666_0003, 4'hF);
    start(32'h3000, 32'd12);
    cycle();
    cycle();
    p0 = n_pops;
    w0 = n_writes;
    check_eq("t3_first_pop", p0, 32'd1);
    repeat (5) cycle();
    check_eq("t3_empty_pops", n_pops, p0);
    check_eq("t3_empty_writes", n_writes, w0);
    check_eq("t3_empty_busy", {31'd0, oBusy}, 32'd1);
    check_eq("t3_empty_write", {31'd0, oWM_write}, 32'd0);
    fifo_q.push_back(32'h6666_0002);
    fifo_q.push_back(32'h6666_0003);
    update_fifo();
    run_until_done(40, "t3");
    check_eq("t3_pops", n_pops, 32'd3);
    check_eq("t3_writes", n_writes, 32'd3);
    check_eq("t3_exp_left", exp_q.size(), 32'd0);

    // 4: zero length completes two cycles after iStart, restart while busy ignored
    fifo_q = '{32'h5555_0001, 32'h5555_0002};
    update_fifo();
    n_pops = 0; n_writes = 0;
    start(32'h4000, 32'd0);
    check_eq("t4_done_cleared", {31'd0, oDone}, 32'd0);
    check_eq("t4_busy", {31'd0, oBusy}, 32'd1);
    iWM_startaddress = 32'h5000;
    iLength          = 32'd16;
    iStart           = 1'b1;
    cycle();
    iStart = 1'b0;
    check_eq("t4_done", {31'd0, oDone}, 32'd1);
    check_eq("t4_busy_end", {31'd0, oBusy}, 32'd0);
    check_eq("t4_state", {30'd0, oDbg_state}, 32'd3);
    repeat (5) cycle();
    check_eq("t4_pops", n_pops, 32'd0);
    check_eq("t4_writes", n_writes, 32'd0);
    check_eq("t4_done_hold", {31'd0, oDone}, 32'd1);
    clear_fifo();

    // 5: asynchronous reset during a stalled write
    fifo_q = '{32'h7777_0001, 32'h7777_0002};
    update_fifo();
    iWM_waitrequest = 1'b1;
    start(32'h7000, 32'd8);
    cycle();
    check_eq("t5_write_before", {31'd0, oWM_write}, 32'd1);
    check_eq("t5_busy_before", {31'd0, oBusy}, 32'd1);
    #3;
    iReset = 1'b1;
    #1;
    check_eq("t5_write", {31'd0, oWM_write}, 32'd0);
    check_eq("t5_pop", {31'd0, oFF_readrequest}, 32'd0);
    check_eq("t5_busy", {31'd0, oBusy}, 32'd0);
    check_eq("t5_done", {31'd0, oDone}, 32'd0);
    check_eq("t5_addr", oWM_writeaddress, 32'd0);
    check_eq("t5_data", oWM_writedata, 32'd0);
    @(posedge iClk);
    #1;
    iReset          = 1'b0;
    iWM_waitrequest = 1'b0;
    clear_fifo();

    // 6: 6 bytes -> partial last word with lane masking, one word without
    fifo_q = '{32'h8888_0001, 32'h8888_0002};
    update_fifo();
    n_pops = 0; n_writes = 0;
    expect_write(32'h6000, 32'h8888_0001, 4'hF);
`ifdef WM_BYTEENABLE_EN
    expect_write(32'h6004, 32'h8888_0002, 4'h3);
`endif
    start(32'h6000, 32'd6);
    run_until_done(40, "t6");
    check_eq("t6_exp_left", exp_q.size(), 32'd0);
`ifdef WM_BYTEENABLE_EN
    check_eq("t6_writes", n_writes, 32'd2);
    check_eq("t6_pops", n_pops, 32'd2);
    check_eq("t6_final_be", {28'd0, oWM_byteenable}, 32'hF);
`else
    check_eq("t6_writes", n_writes, 32'd1);
    check_eq("t6_pops", n_pops, 32'd1);
    check_eq("t6_fifo_left", fifo_q.size(), 32'd1);
`endif
    clear_fifo();

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
